snake_body: RTL and testbench
=============================

SNAKE_BODY -- requirements
Module: snake_body

Interface
REQ-001 Parameter MOVE_DIV, default 25_000_000, clk cycles per move step.
REQ-002 Parameter MAX_LEN, default 16, maximum segment count (4..64).
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous reset, active-high.
REQ-005 state  in  2  game state; 2'b01 = PlayState, every other value = not playing.
REQ-006 Btn_Up/Btn_Down/Btn_Left/Btn_Right  in  1 each  debounced direction requests, level.
REQ-007 Grow  in  1  one-cycle pulse from the food generator: food eaten.
REQ-008 Seg_Index  in  6  body segment select for readout; 0 = head.
REQ-009 Head_X  out  6  head column, grid 0..39; 0 and 39 are walls.
REQ-010 Head_Y  out  6  head row, grid 0..29; 0 and 29 are walls.
REQ-011 Seg_X/Seg_Y  out  6 each  registered coordinates of segment Seg_Index.
REQ-012 Seg_Valid  out  1  registered; 1 when Seg_Index < Length.
REQ-013 Length  out  7  current segment count.
REQ-014 Move  out  1  one-cycle strobe in the cycle the body shifts.
REQ-015 Hit  out  1  collision flag, sticky.

Function
REQ-016 Tick counter SHALL count 0..MOVE_DIV-1 only while state==PlayState and Hit==0; a step occurs when it wraps; counter is held at 0 otherwise.
REQ-017 Direction encoding: up, down, left, right; current direction Dir; pending Dir_Req.
REQ-018 Each cycle at most one button is sampled, priority Up>Down>Left>Right; it loads Dir_Req unless it is the reverse of Dir.
REQ-019 On a step Dir SHALL take Dir_Req; next head = head moved one cell in Dir (up = Y-1, right = X+1).
REQ-020 Grow pulse SHALL set Grow_Pend; a step consumes it; Grow coincident with a step applies to that step.
REQ-021 On a step with Grow_Pend: segments shift toward tail, new head inserted, Length+1, saturating at MAX_LEN (at MAX_LEN the tail is dropped as a normal step).
REQ-022 On a step without Grow_Pend: segments shift, tail dropped, Length unchanged.
REQ-023 Collision: next head on a wall cell, or equal to segment i for 0<=i<Length-1 (current tail excluded when not growing; included when growing).
REQ-024 On collision Hit SHALL go 1, body and head SHALL NOT move, Move SHALL stay 0; Hit holds until state leaves PlayState or rst.
REQ-025 Move pulses in the same cycle the new Head_X/Head_Y appear on the outputs.
REQ-026 Seg_X/Seg_Y/Seg_Valid SHALL reflect Seg_Index and body contents with one-cycle latency; out-of-range index gives Seg_Valid=0, Seg_X=Seg_Y=0.
REQ-027 Any state other than PlayState SHALL reload reset values (REQ-028) each cycle.

Reset
REQ-028 rst SHALL immediately set: segments (20,15),(19,15),(18,15), Length=3, Head=(20,15), Dir=Dir_Req=right, Grow_Pend=0, Hit=0, Move=0, tick counter=0, Seg_X=Seg_Y=0, Seg_Valid=0.
REQ-029 rst mid-step SHALL discard the step; the first step after release occurs MOVE_DIV cycles after state==PlayState is seen.

Configuration
REQ-030 Macro SNAKE_WRAP_EN defined: walls are not collisions; next head at X=0 becomes X=38, X=39 becomes X=1, Y=0 becomes Y=28, Y=29 becomes Y=1; self-collision still sets Hit.
REQ-031 SNAKE_WRAP_EN undefined: wall cells cause Hit per REQ-023.

Verification (MOVE_DIV=4)
REQ-032 rst, state=01, no buttons, 3 steps -> Head (21,15),(22,15),(23,15); Length=3; Move once per 4 cycles.
REQ-033 Btn_Left while moving right -> ignored, Head continues to X+1; Btn_Up then step -> Head Y-1.
REQ-034 Grow pulse on step cycle, then a second Grow pulse before the next step -> Length 3->4->5, one per step; Length saturates at MAX_LEN.
REQ-035 Run right from (20,15) without wrap -> step onto X=39 sets Hit, Head stays (38,15), Move stops; with SNAKE_WRAP_EN -> Head becomes (1,15), Hit=0.
REQ-036 Length 5, turn up/left/down into own body -> Hit=1; state=00 -> reset values, Hit=0; Seg_Index=2 -> Seg_X/Seg_Y=(18,15), Seg_Valid=1 one cycle later; Seg_Index=3 -> Seg_Valid=0.

Source files
------------

// File: rtl/snake_body.sv
// Snake body for a 40x30 grid: move timing, steering, growth, collision and segment readout.
// Optional macro SNAKE_WRAP_EN: the border wraps around to the opposite inner cell instead of being a wall.
module snake_body #(
    parameter int MOVE_DIV = 25_000_000,
    parameter int MAX_LEN  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       Btn_Up,
    input  logic       Btn_Down,
    input  logic       Btn_Left,
    input  logic       Btn_Right,
    input  logic       Grow,
    input  logic [5:0] Seg_Index,
    output logic [5:0] Head_X,
    output logic [5:0] Head_Y,
    output logic [5:0] Seg_X,
    output logic [5:0] Seg_Y,
    output logic       Seg_Valid,
    output logic [6:0] Length,
    output logic       Move,
    output logic       Hit
);

    // Opposite directions differ only in bit 0.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [1:0] PLAY_STATE = 2'b01;
    localparam int         IW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int         CW         = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(MOVE_DIV - 1);
    localparam logic [6:0] LEN_MAX    = 7'(MAX_LEN);
    localparam logic [6:0] LEN_START  = 7'd3;
    localparam logic [5:0] X_WALL_HI  = 6'd39;
    localparam logic [5:0] Y_WALL_HI  = 6'd29;

    function automatic dir_t reverse_of(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

    function automatic logic [5:0] home_x(input int i);
        return (i < 3) ? 6'(20 - i) : 6'd0;
    endfunction

    function automatic logic [5:0] home_y(input int i);
        return (i < 3) ? 6'd15 : 6'd0;
    endfunction

    logic [5:0]    seg_x [MAX_LEN];
    logic [5:0]    seg_y [MAX_LEN];
    logic [CW-1:0] tick;
    dir_t          dir;
    dir_t          dir_req;
    logic          grow_pend;

    logic          playing;
    logic          step;
    logic          growing;
    logic          btn_hit;
    dir_t          btn_dir;
    logic          load_req;
    logic [5:0]    nx;
    logic [5:0]    ny;
    logic          wall;
    logic          self_hit;
    logic          collide;
    logic [6:0]    check_len;
    logic          valid_sel;
    logic [IW-1:0] sel;

    assign Head_X = seg_x[0];
    assign Head_Y = seg_y[0];

    // NOTE: every signal written here is given a default first so no latch can be inferred.
    always_comb begin
        playing = (state == PLAY_STATE);
        step    = playing && !Hit && (tick == TICK_LAST);
        // At MAX_LEN a grow request degenerates into a normal step.
        growing = (grow_pend || Grow) && (Length < LEN_MAX);

        btn_hit = 1'b1;
        btn_dir = DIR_RIGHT;
        if (Btn_Up)         btn_dir = DIR_UP;
        else if (Btn_Down)  btn_dir = DIR_DOWN;
        else if (Btn_Left)  btn_dir = DIR_LEFT;
        else if (Btn_Right) btn_dir = DIR_RIGHT;
        else                btn_hit = 1'b0;
        load_req = btn_hit && (btn_dir != reverse_of(dir));

        nx = seg_x[0];
        ny = seg_y[0];
        case (dir_req)
            DIR_UP:   ny = seg_y[0] - 6'd1;
            DIR_DOWN: ny = seg_y[0] + 6'd1;
            DIR_LEFT: nx = seg_x[0] - 6'd1;
            default:  nx = seg_x[0] + 6'd1;
        endcase

        wall = 1'b0;
`ifdef SNAKE_WRAP_EN
        if (nx == 6'd0)           nx = X_WALL_HI - 6'd1;
        else if (nx == X_WALL_HI) nx = 6'd1;
        if (ny == 6'd0)           ny = Y_WALL_HI - 6'd1;
        else if (ny == Y_WALL_HI) ny = 6'd1;
`else
        wall = (nx == 6'd0) || (nx == X_WALL_HI) || (ny == 6'd0) || (ny == Y_WALL_HI);
`endif

        // The tail cell is vacated by a normal step, so it only blocks when growing.
        check_len = growing ? Length : Length - 7'd1;
        self_hit  = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((7'(i) < check_len) && (seg_x[i] == nx) && (seg_y[i] == ny))
                self_hit = 1'b1;
        end
        collide = wall || self_hit;

        valid_sel = ({1'b0, Seg_Index} < Length);
        sel       = Seg_Index[IW-1:0];
    end

    // NOTE: the segment array is reset like every other register because the start body is game state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= home_x(i);
                seg_y[i] <= home_y(i);
            end
            Length    <= LEN_START;
            dir       <= DIR_RIGHT;
            dir_req   <= DIR_RIGHT;
            grow_pend <= 1'b0;
            Hit       <= 1'b0;
            Move      <= 1'b0;
            tick      <= '0;
            Seg_X     <= 6'd0;
            Seg_Y     <= 6'd0;
            Seg_Valid <= 1'b0;
        end else if (!playing) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= home_x(i);
                seg_y[i] <= home_y(i);
            end
            Length    <= LEN_START;
            dir       <= DIR_RIGHT;
            dir_req   <= DIR_RIGHT;
            grow_pend <= 1'b0;
            Hit       <= 1'b0;
            Move      <= 1'b0;
            tick      <= '0;
            Seg_X     <= 6'd0;
            Seg_Y     <= 6'd0;
            Seg_Valid <= 1'b0;
        end else begin
            tick <= (Hit || step) ? '0 : tick + 1'b1;
            Move <= 1'b0;
            if (load_req)
                dir_req <= btn_dir;
            if (Grow)
                grow_pend <= 1'b1;
            if (step) begin
                if (collide) begin
                    Hit <= 1'b1;
                end else begin
                    for (int i = MAX_LEN - 1; i > 0; i--) begin
                        seg_x[i] <= seg_x[i-1];
                        seg_y[i] <= seg_y[i-1];
                    end
                    seg_x[0]  <= nx;
                    seg_y[0]  <= ny;
                    dir       <= dir_req;
                    grow_pend <= 1'b0;
                    Move      <= 1'b1;
                    if (growing)
                        Length <= Length + 7'd1;
                end
            end
            Seg_Valid <= valid_sel;
            Seg_X     <= valid_sel ? seg_x[sel] : 6'd0;
            Seg_Y     <= valid_sel ? seg_y[sel] : 6'd0;
        end
    end

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: directed game scenarios, then random play checked cycle by cycle
// against a queue-based model of the snake.
module tb_snake_body;

    localparam int DIV  = 4;
    localparam int MAXL = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] st;
    logic       bu, bd, bl, br, gr;
    logic [5:0] idx;
    logic [5:0] head_x, head_y, seg_x, seg_y;
    logic       seg_valid, move, hit;
    logic [6:0] length;

    int n_tests = 0;
    int n_fail  = 0;

    snake_body #(.MOVE_DIV(DIV), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .state(st),
        .Btn_Up(bu), .Btn_Down(bd), .Btn_Left(bl), .Btn_Right(br),
        .Grow(gr), .Seg_Index(idx),
        .Head_X(head_x), .Head_Y(head_y), .Seg_X(seg_x), .Seg_Y(seg_y),
        .Seg_Valid(seg_valid), .Length(length), .Move(move), .Hit(hit)
    );

    always #5 clk = ~clk;

    // Model: body as coordinate queues, head first; directions 0=up 1=down 2=left 3=right.
    int dx [4] = '{0, 0, -1, 1};
    int dy [4] = '{-1, 1, 0, 0};
    int qx[$];
    int qy[$];
    int m_dir, m_req, m_tick, m_grow, m_hit, m_move, m_sx, m_sy, m_sv;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        qx = {20, 19, 18};
        qy = {15, 15, 15};
        m_dir = 3; m_req = 3; m_tick = 0; m_grow = 0; m_hit = 0; m_move = 0;
        m_sx = 0; m_sy = 0; m_sv = 0;
    endtask

    task automatic model_cycle();
        int  hx, hy, lim, b, old_dir, old_req;
        bit  step, growing, wall, self_hit;
        if (st != 2'b01) begin
            model_reset();
            return;
        end
        if (int'(idx) < qx.size()) begin
            m_sv = 1; m_sx = qx[idx]; m_sy = qy[idx];
        end else begin
            m_sv = 0; m_sx = 0; m_sy = 0;
        end
        step    = (m_hit == 0) && (m_tick == DIV - 1);
        m_tick  = (m_hit != 0 || step) ? 0 : m_tick + 1;
        m_move  = 0;
        old_dir = m_dir;
        old_req = m_req;
        if (gr) m_grow = 1;
        if (step) begin
            growing = (m_grow != 0) && (qx.size() < MAXL);
            hx = qx[0] + dx[old_req];
            hy = qy[0] + dy[old_req];
`ifdef SNAKE_WRAP_EN
            if (hx == 0) hx = 38; else if (hx == 39) hx = 1;
            if (hy == 0) hy = 28; else if (hy == 29) hy = 1;
            wall = 0;
`else
            wall = (hx == 0 || hx == 39 || hy == 0 || hy == 29);
`endif
            lim = growing ? qx.size() : qx.size() - 1;
            self_hit = 0;
            for (int i = 0; i < lim; i++)
                if (qx[i] == hx && qy[i] == hy) self_hit = 1;
            if (wall || self_hit) begin
                m_hit = 1;
            end else begin
                m_dir = old_req;
                qx.push_front(hx);
                qy.push_front(hy);
                if (!growing) begin
                    void'(qx.pop_back());
                    void'(qy.pop_back());
                end
                m_grow = 0;
                m_move = 1;
            end
        end
        b = bu ? 0 : bd ? 1 : bl ? 2 : br ? 3 : -1;
        if (b >= 0 && !(dx[b] == -dx[old_dir] && dy[b] == -dy[old_dir]))
            m_req = b;
    endtask

    task automatic compare_all();
        check("head_x", head_x, qx[0]);
        check("head_y", head_y, qy[0]);
        check("length", length, qx.size());
        check("move", move, m_move);
        check("hit", hit, m_hit);
        check("seg_valid", seg_valid, m_sv);
        check("seg_x", seg_x, m_sx);
        check("seg_y", seg_y, m_sy);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        model_cycle();
        compare_all();
    endtask

    // Reset is raised mid-cycle so its effect must be visible before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_head_x", head_x, 20);
        check("rst_head_y", head_y, 15);
        check("rst_length", length, 3);
        check("rst_hit", hit, 0);
        check("rst_move", move, 0);
        check("rst_seg_valid", seg_valid, 0);
        check("rst_seg_x", seg_x, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; st = 2'b00; idx = '0;
        bu = 0; bd = 0; bl = 0; br = 0; gr = 0;
        #3;
        do_reset();

        // Straight run: one step per DIV cycles.
        st = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            repeat (DIV - 1) cyc();
            cyc();
            check("run_head_x", head_x, 20 + k);
            check("run_head_y", head_y, 15);
            check("run_move", move, 1);
        end
        check("run_length", length, 3);

        // Reverse request ignored, then a legal turn.
        bl = 1; cyc(); bl = 0;
        repeat (DIV - 1) cyc();
        check("rev_head_x", head_x, 24);
        check("rev_head_y", head_y, 15);
        bu = 1; cyc(); bu = 0;
        repeat (DIV - 1) cyc();
        check("up_head_x", head_x, 24);
        check("up_head_y", head_y, 14);

        // Growth: pulse on the step cycle, then one ahead of the next step, then saturation.
        repeat (DIV - 1) cyc();
        gr = 1; cyc(); gr = 0;
        check("grow_len4", length, 4);
        gr = 1; cyc(); gr = 0;
        repeat (DIV - 1) cyc();
        check("grow_len5", length, 5);
        repeat (3) begin
            repeat (DIV - 1) cyc();
            gr = 1; cyc(); gr = 0;
        end
        check("grow_sat", length, MAXL);
        check("grow_head_y", head_y, 9);

        // Run into the right wall from the start position.
        st = 2'b00; cyc(); st = 2'b01;
        repeat (19 * DIV) cyc();
`ifdef SNAKE_WRAP_EN
        check("wall_head_x", head_x, 1);
        check("wall_hit", hit, 0);
`else
        check("wall_head_x", head_x, 38);
        check("wall_hit", hit, 1);
        repeat (2 * DIV) cyc();
        check("wall_frozen_x", head_x, 38);
        check("wall_move", move, 0);
`endif

        // Length 5, then up/left/down bites the body.
        st = 2'b00; cyc(); st = 2'b01;
        repeat (2) begin
            gr = 1; cyc(); gr = 0;
            repeat (DIV - 1) cyc();
        end
        check("bite_len", length, 5);
        bu = 1; cyc(); bu = 0; repeat (DIV - 1) cyc();
        bl = 1; cyc(); bl = 0; repeat (DIV - 1) cyc();
        bd = 1; cyc(); bd = 0; repeat (DIV - 1) cyc();
        check("bite_hit", hit, 1);
        check("bite_head_x", head_x, 21);
        check("bite_head_y", head_y, 14);
        st = 2'b00; cyc();
        check("idle_hit", hit, 0);
        check("idle_length", length, 3);
        check("idle_head_x", head_x, 20);
        st = 2'b01; idx = 6'd2; cyc();
        check("rd2_x", seg_x, 18);
        check("rd2_y", seg_y, 15);
        check("rd2_valid", seg_valid, 1);
        idx = 6'd3; cyc();
        check("rd3_valid", seg_valid, 0);
        check("rd3_x", seg_x, 0);
        check("rd3_y", seg_y, 0);

        // Random play against the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            r  = $urandom_range(0, 15);
            bu = (r == 0) || (r == 4);
            bd = (r == 1) || (r == 5);
            bl = (r == 2) || (r == 4);
            br = (r == 3) || (r == 5);
            gr = ($urandom_range(0, 11) == 0);
            idx = 6'($urandom_range(0, 8));
            if (m_hit != 0)
                st = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            else
                st = ($urandom_range(0, 299) == 0) ? 2'($urandom_range(2, 3)) : 2'b01;
            if ($urandom_range(0, 399) == 0)
                do_reset();
            else
                cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
